pairing_job_ctrl: RTL and testbench

- Job sequencer that front-ends one Tate-pairing core (GF(3^m) Duursma-Lee plus final exponentiation) with a valid/ready job interface.
- Accepts a tagged operand set and holds the operands stable on the core inputs.
- Pulses the core reset, then waits for core done under a watchdog.
- Reads the result back through the core's 8-way one-hot slice select and streams the slices out as tagged beats.

---
 rtl/pairing_pkg.sv | 23 ++
 rtl/pairing_watchdog.sv | 25 ++
 rtl/pairing_job_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pairing_job_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pairing_pkg.sv
// Shared constants and state encoding for the pairing-core job controller.
// Holds field widths for a GF(3^97) Tate-pairing core and the FSM state enum.
package pairing_pkg;

    localparam int M       = 97;
    localparam int OPW     = 2 * M;
    localparam int SLW     = 150;
    localparam int NSL     = 8;
    localparam int TAGW    = 4;
    localparam int RST_CYC = 2;
    localparam int TMO_W   = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_SEL,
        S_CAP,
        S_OUT,
        S_ERR
    } state_t;

endpackage

// File: rtl/pairing_watchdog.sv
// Free-running up-counter with clear and enable that parks at all-ones.
// Ports: clk, reset, clr (zero the count), en (count up), term (count is all-ones).
module pairing_watchdog #(
    parameter int W = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic term
);

    logic [W-1:0] cnt;

    assign term = &cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en && !term) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pairing_job_ctrl.sv
// Job sequencer for one Tate-pairing core: accepts a tagged job, resets and runs
// the core under a watchdog, then streams the 8 result slices out as tagged beats.
// Ports: job_* (valid/ready job in), core_* (to/from core), res_* (valid/ready
// result beats), busy, jobs_done (completed-job count including timeouts).
module pairing_job_ctrl
    import pairing_pkg::*;
#(
    parameter int OPW     = pairing_pkg::OPW,
    parameter int SLW     = pairing_pkg::SLW,
    parameter int NSL     = pairing_pkg::NSL,
    parameter int TAGW    = pairing_pkg::TAGW,
    parameter int RST_CYC = pairing_pkg::RST_CYC,
    parameter int TMO_W   = pairing_pkg::TMO_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            job_valid,
    output logic            job_ready,
    input  logic [TAGW-1:0] job_tag,
    input  logic [OPW-1:0]  job_x1,
    input  logic [OPW-1:0]  job_y1,
    input  logic [OPW-1:0]  job_x2,
    input  logic [OPW-1:0]  job_y2,
    output logic            core_reset,
    output logic [OPW-1:0]  core_x1,
    output logic [OPW-1:0]  core_y1,
    output logic [OPW-1:0]  core_x2,
    output logic [OPW-1:0]  core_y2,
    input  logic            core_done,
    output logic [NSL-1:0]  core_sel,
    input  logic [SLW-1:0]  core_out,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [SLW-1:0]  res_data,
    output logic [2:0]      res_idx,
    output logic            res_last,
    output logic            res_err,
    output logic [TAGW-1:0] res_tag,
    output logic            busy,
    output logic [15:0]     jobs_done
);

    localparam int RCW = $clog2(RST_CYC + 1);
    localparam logic [NSL-1:0] SEL0 = NSL'(1);

    state_t          state, nxt;
    logic [RCW-1:0]  rst_cnt;
    logic            armed;
    logic [2:0]      idx;
    logic [TAGW-1:0] tag_q;
    logic            wd_clr, wd_en, wd_term;
    logic            accept;

    // rst_cnt doubles as the post-reset hold and the per-job LOAD pulse timer.
    assign core_reset = reset | (rst_cnt != '0);
    assign job_ready  = (state == S_IDLE) & ~reset;
    assign accept     = job_valid & job_ready;
    assign busy       = (state != S_IDLE);
    assign res_tag    = tag_q;

    pairing_watchdog #(
        .W(TMO_W)
    ) u_wd (
        .clk  (clk),
        .reset(reset),
        .clr  (wd_clr),
        .en   (wd_en),
        .term (wd_term)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt    = state;
        wd_clr = 1'b0;
        wd_en  = 1'b0;
        unique case (state)
            S_IDLE: if (accept) nxt = S_LOAD;
            S_LOAD: begin
                wd_clr = 1'b1;
                if (rst_cnt == RCW'(1)) nxt = S_RUN;
            end
            S_RUN: begin
                wd_en = 1'b1;
                // armed is low on the first RUN cycle: done is still stale there.
                if (armed && core_done) nxt = S_SEL;
                else if (wd_term)       nxt = S_ERR;
            end
            S_SEL: nxt = S_CAP;
            S_CAP: nxt = S_OUT;
            S_OUT: if (res_ready) nxt = res_last ? S_IDLE : S_SEL;
            S_ERR: if (res_ready) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rst_cnt   <= RCW'(RST_CYC);
            armed     <= 1'b0;
            idx       <= '0;
            tag_q     <= '0;
            core_x1   <= '0;
            core_y1   <= '0;
            core_x2   <= '0;
            core_y2   <= '0;
            core_sel  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            res_last  <= 1'b0;
            res_err   <= 1'b0;
            jobs_done <= '0;
        end else begin
            armed <= (state == S_RUN);
            if (accept) begin
                core_x1 <= job_x1;
                core_y1 <= job_y1;
                core_x2 <= job_x2;
                core_y2 <= job_y2;
                tag_q   <= job_tag;
                rst_cnt <= RCW'(RST_CYC);
            end else if (rst_cnt != '0) begin
                rst_cnt <= rst_cnt - 1'b1;
            end
            unique case (state)
                S_RUN: begin
                    if (nxt == S_SEL) begin
                        idx <= '0;
                    end else if (nxt == S_ERR) begin
                        res_valid <= 1'b1;
                        res_err   <= 1'b1;
                        res_last  <= 1'b1;
                        res_idx   <= '0;
                        res_data  <= '0;
                    end
                end
                S_SEL: core_sel <= SEL0 << idx;
                S_CAP: begin
                    res_data  <= core_out;
                    res_idx   <= idx;
                    res_last  <= (idx == 3'(NSL - 1));
                    res_err   <= 1'b0;
                    res_valid <= 1'b1;
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (res_last) begin
                            core_sel  <= '0;
                            jobs_done <= jobs_done + 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_ERR: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_err   <= 1'b0;
                        jobs_done <= jobs_done + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pairing_job_ctrl.sv
// Self-checking bench for pairing_job_ctrl with a behavioural core stub.
// Expected beats come from a queue model built from the job rules.
module tb_pairing_job_ctrl;
    import pairing_pkg::*;

    localparam int TW = 9;
    localparam int RC = 2;

    typedef struct {
        logic [TAGW-1:0] tag;
        logic [2:0]      idx;
        logic [SLW-1:0]  data;
        logic            last;
        logic            err;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            job_valid = 1'b0;
    logic            job_ready;
    logic [TAGW-1:0] job_tag = '0;
    logic [OPW-1:0]  job_x1 = '0, job_y1 = '0;
    logic [OPW-1:0]  job_x2 = '0, job_y2 = '0;
    logic            core_reset;
    logic [OPW-1:0]  core_x1, core_y1, core_x2, core_y2;
    logic            core_done;
    logic [NSL-1:0]  core_sel;
    logic [SLW-1:0]  core_out;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [SLW-1:0]  res_data;
    logic [2:0]      res_idx;
    logic            res_last, res_err;
    logic [TAGW-1:0] res_tag;
    logic            busy;
    logic [15:0]     jobs_done;

    pairing_job_ctrl #(
        .RST_CYC(RC),
        .TMO_W  (TW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_tag   (job_tag),
        .job_x1    (job_x1),
        .job_y1    (job_y1),
        .job_x2    (job_x2),
        .job_y2    (job_y2),
        .core_reset(core_reset),
        .core_x1   (core_x1),
        .core_y1   (core_y1),
        .core_x2   (core_x2),
        .core_y2   (core_y2),
        .core_done (core_done),
        .core_sel  (core_sel),
        .core_out  (core_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_idx   (res_idx),
        .res_last  (res_last),
        .res_err   (res_err),
        .res_tag   (res_tag),
        .busy      (busy),
        .jobs_done (jobs_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Core stub: done stays stale for two cycles after core_reset rises,
    // then rises lat_cfg cycles after the reset has propagated.
    int             lat_cfg = 10;
    bit             never_cfg = 1'b0;
    logic [SLW-1:0] base_cfg = '0;
    logic [1:0]     crd = '0;
    logic           done_r = 1'b1;
    int             dcnt = 0;

    always @(posedge clk) begin
        crd <= {crd[0], core_reset};
        if (crd[1]) begin
            done_r <= 1'b0;
            dcnt   <= 0;
        end else if (!done_r && !never_cfg) begin
            dcnt <= dcnt + 1;
            if (dcnt + 1 >= lat_cfg) done_r <= 1'b1;
        end
    end
    assign core_done = done_r;

    always_comb begin
        core_out = '0;
        for (int k = 0; k < NSL; k++)
            if (core_sel[k]) core_out = base_cfg + SLW'(k);
    end

    int cr_hi = 0;
    always @(negedge clk) if (core_reset) cr_hi++;

    // Cycle monitor: select legality and beat stability under backpressure.
    logic           pv = 1'b0, prdy = 1'b0, pl, pe;
    logic [SLW-1:0] pdat;
    logic [2:0]     pidx;
    logic [NSL-1:0] psel;

    always @(negedge clk) begin
        if (reset) begin
            pv = 1'b0;
        end else begin
            chk("sel_onehot0", 256'($onehot0(core_sel)), 1);
            chk("ready_while_busy", job_ready & busy, 0);
            if (pv && !prdy) begin
                chk("hold_valid", res_valid, 1);
                chk("hold_data", res_data, pdat);
                chk("hold_idx", res_idx, pidx);
                chk("hold_sel", core_sel, psel);
                chk("hold_last_err", {res_last, res_err}, {pl, pe});
            end
            pv   = res_valid;
            prdy = res_ready;
            pdat = res_data;
            pidx = res_idx;
            psel = core_sel;
            pl   = res_last;
            pe   = res_err;
        end
    end

    beat_t       q[$];
    logic [15:0] exp_jobs = '0;
    int          last_hs = 0;
    bit          chk_gap = 1'b0;

    function automatic logic [OPW-1:0] rnd_op();
        logic [223:0] r;
        for (int i = 0; i < 7; i++) r[i*32+:32] = $urandom;
        return r[OPW-1:0];
    endfunction

    function automatic logic [SLW-1:0] rnd_base();
        logic [159:0] r;
        for (int i = 0; i < 5; i++) r[i*32+:32] = $urandom;
        return r[SLW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [TAGW-1:0] tag, input int lat,
                           input logic [SLW-1:0] base, input bit never,
                           input int stall_b, input int stall_n,
                           input int rst_b, input bit hold,
                           input logic [TAGW-1:0] tag2, input bit stale);
        logic [OPW-1:0] o[4];
        logic [NSL-1:0] es;
        int    acc, t0, lo, hi, n, nb;
        bit    ok;
        beat_t e;
        for (int i = 0; i < 4; i++) o[i] = rnd_op();
        job_tag   = tag;
        job_x1    = o[0];
        job_y1    = o[1];
        job_x2    = o[2];
        job_y2    = o[3];
        job_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (job_ready) ok = 1'b1;
            else tick();
        end
        if (!ok) begin
            chk("accept_wait", 0, 1);
            job_valid = 1'b0;
            return;
        end
        if (stale) chk("stale_done_at_accept", core_done, 1);
        lat_cfg   = lat;
        base_cfg  = base;
        never_cfg = never;
        @(posedge clk);
        #1;
        acc   = cyc;
        cr_hi = 0;
        if (chk_gap) chk("b2b_accept_gap", acc - last_hs, 1);
        if (hold) job_tag = tag2;
        else job_valid = 1'b0;
        job_x1 = ~o[0];
        job_y1 = ~o[1];
        job_x2 = ~o[2];
        job_y2 = ~o[3];
        if (never) begin
            q.push_back('{tag, 3'd0, '0, 1'b1, 1'b1});
            lo = 2 ** TW;
            hi = 2 ** TW + RC + 6;
        end else begin
            for (int k = 0; k < NSL; k++)
                q.push_back('{tag, 3'(k), base + SLW'(k), k == NSL - 1, 1'b0});
            lo = lat + 1;
            hi = lat + 12;
        end
        nb = q.size();
        for (int b = 0; b < nb; b++) begin
            ok = 1'b0;
            for (int i = 0; i < 3000 && !ok; i++) begin
                if (res_valid) ok = 1'b1;
                else tick();
            end
            if (!ok) begin
                chk("beat_wait", 0, 1);
                q.delete();
                return;
            end
            if (b == 0) begin
                t0 = cyc - acc;
                chk("first_beat_latency_ok", 256'(t0 >= lo && t0 <= hi), 1);
                chk("op_x1", core_x1, o[0]);
                chk("op_y1", core_y1, o[1]);
                chk("op_x2", core_x2, o[2]);
                chk("op_y2", core_y2, o[3]);
            end
            e = q.pop_front();
            es = e.err ? '0 : (NSL'(1) << e.idx);
            chk("beat_tag", res_tag, e.tag);
            chk("beat_idx", res_idx, e.idx);
            chk("beat_data", res_data, e.data);
            chk("beat_last", res_last, e.last);
            chk("beat_err", res_err, e.err);
            chk("beat_sel", core_sel, es);
            if (b == rst_b) begin
                reset = 1'b1;
                tick();
                chk("rst_valid", res_valid, 0);
                chk("rst_core_reset", core_reset, 1);
                chk("rst_jobs_done", jobs_done, 0);
                chk("rst_ready", job_ready, 0);
                chk("rst_busy", busy, 0);
                chk("rst_sel", core_sel, 0);
                reset = 1'b0;
                exp_jobs = '0;
                q.delete();
                tick();
                chk("post_rst_core_reset", core_reset, 1);
                chk("post_rst_ready", job_ready, 1);
                repeat (3) tick();
                chk("post_rst_core_reset_low", core_reset, 0);
                return;
            end
            n = (b == stall_b) ? stall_n : $urandom_range(0, 2);
            repeat (n) tick();
            if (b == stall_b) begin
                chk("stall_valid", res_valid, 1);
                chk("stall_idx", res_idx, e.idx);
                chk("stall_data", res_data, e.data);
                chk("stall_sel", core_sel, es);
            end
            res_ready = 1'b1;
            @(posedge clk);
            #1;
            res_ready = 1'b0;
            last_hs = cyc;
        end
        exp_jobs++;
        chk("jobs_done", jobs_done, exp_jobs);
        chk("idle_after_job", busy, 0);
        chk("ready_after_job", job_ready, 1);
        chk("valid_after_job", res_valid, 0);
        chk("core_reset_cycles", cr_hi, RC);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout after %0d cycles", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        chk("reset_ready", job_ready, 0);
        chk("reset_core_reset", core_reset, 1);
        chk("reset_sel", core_sel, 0);
        chk("reset_valid", res_valid, 0);
        chk("reset_err_last", {res_err, res_last}, 0);
        chk("reset_idx", res_idx, 0);
        chk("reset_busy", busy, 0);
        chk("reset_jobs", jobs_done, 0);
        chk("reset_ops", {core_x1, core_y1[61:0]}, 0);
        reset = 1'b0;
        repeat (5) tick();
        chk("idle_ready", job_ready, 1);
        chk("idle_core_reset", core_reset, 0);

        // single job, then backpressure on beat 3
        run_job(4'd5, 300, 150'h100, 0, -1, 0, -1, 0, 4'd0, 0);
        run_job(4'd9, 40, rnd_base(), 0, 3, 10, -1, 0, 4'd0, 0);
        // previous done is still high at accept
        run_job(4'd3, 25, rnd_base(), 0, -1, 0, -1, 0, 4'd0, 1);
        // back-to-back with job_valid held
        run_job(4'd1, 30, rnd_base(), 0, -1, 0, -1, 1, 4'd2, 0);
        chk_gap = 1'b1;
        run_job(4'd2, 20, rnd_base(), 0, -1, 0, -1, 0, 4'd0, 0);
        chk_gap = 1'b0;
        tick();
        // watchdog expiry
        run_job(4'd7, 0, rnd_base(), 1, -1, 0, -1, 0, 4'd0, 0);
        chk("err_sel_zero", core_sel, 0);
        for (int j = 0; j < 3; j++)
            run_job(4'($urandom), $urandom_range(3, 150), rnd_base(),
                    0, -1, 0, -1, 0, 4'd0, 0);
        // reset during beat 4, then a normal job
        run_job(4'd11, 15, rnd_base(), 0, -1, 0, 4, 0, 4'd0, 0);
        run_job(4'd12, 35, rnd_base(), 0, -1, 0, -1, 0, 4'd0, 0);
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
